// File: rtl/exec_sequencer.sv
// Run/stop execution sequencer: walks each instruction through NUM_PHASES phases,
// stops only on instruction boundaries, and keeps cycle/instruction counters.
module exec_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int PC_WIDTH   = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exec,
  input  logic                 step_mode,
  input  logic                 hlt,
  input  logic                 stall,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 bp_en,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic                 cnt_clr,
  output logic [3:0]           phase,
  output logic                 executing,
  output logic                 instr_done,
  output logic                 halted,
  output logic [1:0]           stop_cause,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [3:0] LAST_PHASE = 4'(NUM_PHASES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_n;
  logic [3:0] phase_n;
  logic [3:0] pend, pend_n, pend_all;   // {hlt, bp, step, user}
  logic [1:0] stop_cause_n;
  logic       halted_n;
  logic       sync1, sync2, sync_d;
  logic       press, bp_hit, step_hit, done_c;

  // Two-flop synchronizer plus one delay flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= exec;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign press    = sync_d & ~sync2;
  assign bp_hit   = bp_en && (pc == bp_addr) && (phase == 4'd1);
  assign step_hit = step_mode && (phase == 4'd1);
  assign pend_all = pend | {hlt, bp_hit, step_hit, press};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      phase      <= 4'd0;
      pend       <= 4'd0;
      stop_cause <= 2'd0;
      halted     <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      pend       <= pend_n;
      stop_cause <= stop_cause_n;
      halted     <= halted_n;
    end
  end

  always_comb begin
    state_n      = state;
    phase_n      = phase;
    pend_n       = pend;
    stop_cause_n = stop_cause;
    halted_n     = halted;
    done_c       = 1'b0;
    case (state)
      IDLE: begin
        pend_n = 4'd0;
        if (press && !halted) begin
          state_n = RUN;
          phase_n = 4'd1;
        end
      end
      RUN: begin
        pend_n = pend_all;
        if (!stall) begin
          if (phase == LAST_PHASE) begin
            done_c = 1'b1;
            if (|pend_all) begin
              state_n = IDLE;
              phase_n = 4'd0;
              pend_n  = 4'd0;
              if (pend_all[3])      stop_cause_n = 2'd3;
              else if (pend_all[2]) stop_cause_n = 2'd2;
              else if (pend_all[1]) stop_cause_n = 2'd1;
              else                  stop_cause_n = 2'd0;
              if (pend_all[3]) halted_n = 1'b1;
            end else begin
              phase_n = 4'd1;
            end
          end else begin
            phase_n = phase + 4'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = 4'd0;
      end
    endcase
  end

  // Gated by rst so an instruction aborted by reset never reports completion
  assign instr_done = done_c & rst;
  assign executing  = (phase != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (executing)  cycle_count <= cycle_count + 1'b1;
      if (instr_done) instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: default instance plus a CNT_WIDTH=4 instance for wrap checks.
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst, exec, step_mode, hlt, stall, bp_en, cnt_clr;
  logic [15:0] pc, bp_addr;

  logic [3:0]  phase, phase_4;
  logic        executing, executing_4, instr_done, instr_done_4, halted, halted_4;
  logic [1:0]  stop_cause, stop_cause_4;
  logic [31:0] cycle_count, instr_count;
  logic [3:0]  cycle_count_4, instr_count_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .exec(exec), .step_mode(step_mode), .hlt(hlt), .stall(stall),
    .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr), .cnt_clr(cnt_clr),
    .phase(phase), .executing(executing), .instr_done(instr_done), .halted(halted),
    .stop_cause(stop_cause), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  exec_sequencer #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .exec(exec), .step_mode(step_mode), .hlt(hlt), .stall(stall),
    .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr), .cnt_clr(cnt_clr),
    .phase(phase_4), .executing(executing_4), .instr_done(instr_done_4), .halted(halted_4),
    .stop_cause(stop_cause_4), .cycle_count(cycle_count_4), .instr_count(instr_count_4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Press from IDLE: phase reaches 1 on the third edge; exec is then released
  task automatic do_press();
    exec = 1'b0;
    ticks(3);
    exec = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; exec = 1'b1; step_mode = 1'b0; hlt = 1'b0; stall = 1'b0;
    bp_en = 1'b0; cnt_clr = 1'b0; pc = 16'h0; bp_addr = 16'h0;
    ticks(2);
    chk("rst_phase", phase, 0);
    chk("rst_executing", executing, 0);
    chk("rst_instr_done", instr_done, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stop_cause", stop_cause, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_instr_count", instr_count, 0);
    rst = 1'b1;

    // hlt and stall in IDLE do nothing
    hlt = 1'b1; stall = 1'b1;
    ticks(2);
    chk("idle_hlt_halted", halted, 0);
    chk("idle_hlt_phase", phase, 0);
    hlt = 1'b0; stall = 1'b0;

    // Free run: 10 instructions, phases 1..5 repeating
    do_press();
    chk("run_start_phase", phase, 1);
    chk("run_start_cycles", cycle_count, 0);
    for (int i = 0; i < 50; i++) begin
      chk("run_phase", phase, (i % 5) + 1);
      chk("run_done", instr_done, (i % 5) == 4);
      tick();
    end
    chk("run_cycle_count", cycle_count, 50);
    chk("run_instr_count", instr_count, 10);
    // User press mid-instruction stops at the boundary
    do_press();
    chk("user_mid_phase", phase, 4);
    ticks(2);
    chk("user_stop_phase", phase, 0);
    chk("user_stop_cause", stop_cause, 0);
    chk("user_halted", halted, 0);
    chk("user_cycle_count", cycle_count, 55);
    chk("user_instr_count", instr_count, 11);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cycle_count", cycle_count, 0);
    chk("clr_instr_count", instr_count, 0);
    ticks(2);

    // Single step
    step_mode = 1'b1;
    do_press();
    chk("step_phase1", phase, 1);
    ticks(4);
    chk("step_phase5", phase, 5);
    chk("step_done", instr_done, 1);
    tick();
    step_mode = 1'b0;
    chk("step_stop_phase", phase, 0);
    chk("step_stop_cause", stop_cause, 1);
    chk("step_instr_count", instr_count, 1);
    chk("step_cycle_count", cycle_count, 5);
    ticks(3);

    // Breakpoint in phase 1 of the second instruction, coinciding with a press
    bp_en = 1'b1; bp_addr = 16'h0040; pc = 16'h0000;
    do_press();
    ticks(3);
    chk("bp_phase4", phase, 4);
    exec = 1'b0; pc = 16'h0040;
    ticks(2);
    chk("bp_phase1", phase, 1);
    exec = 1'b1;
    ticks(4);
    chk("bp_phase5", phase, 5);
    tick();
    chk("bp_stop_phase", phase, 0);
    chk("bp_stop_cause", stop_cause, 2);
    bp_en = 1'b0; pc = 16'h0000;
    ticks(3);

    // hlt in phase 3: finish instruction, then halt sticks
    do_press();
    ticks(2);
    chk("hlt_phase3", phase, 3);
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    chk("hlt_phase4", phase, 4);
    tick();
    chk("hlt_phase5", phase, 5);
    tick();
    chk("hlt_stop_phase", phase, 0);
    chk("hlt_halted", halted, 1);
    chk("hlt_stop_cause", stop_cause, 3);
    ticks(3);
    do_press();
    chk("halted_press_phase", phase, 0);
    ticks(3);
    pulse_reset();
    chk("post_rst_halted", halted, 0);
    chk("post_rst_cause", stop_cause, 0);
    do_press();
    chk("post_rst_start", phase, 1);

    // Reset at the last phase aborts without instr_done
    ticks(4);
    chk("abort_phase5", phase, 5);
    chk("abort_done_pre", instr_done, 1);
    rst = 1'b0;
    #1;
    chk("abort_done_in_rst", instr_done, 0);
    tick();
    chk("abort_phase", phase, 0);
    chk("abort_instr_count", instr_count, 0);
    rst = 1'b1;
    ticks(2);

    // Stall 3 cycles in phase 2; step mode stops after this instruction
    step_mode = 1'b1;
    do_press();
    tick();
    step_mode = 1'b0;
    chk("stall_phase2", phase, 2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", phase, 2);
    end
    stall = 1'b0;
    ticks(3);
    chk("stall_phase5", phase, 5);
    tick();
    chk("stall_stop_phase", phase, 0);
    chk("stall_cycle_count", cycle_count, 8);
    chk("stall_instr_count", instr_count, 1);

    // 4-bit counter wrap, then cnt_clr on an instr_done cycle
    pulse_reset();
    do_press();
    ticks(85);
    chk("wrap_phase", phase_4, 1);
    chk("wrap_instr_count4", instr_count_4, 1);
    chk("wrap_cycle_count4", cycle_count_4, 5);
    chk("wrap_instr_count32", instr_count, 17);
    ticks(4);
    chk("wrap_done4", instr_done_4, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_win_instr4", instr_count_4, 0);
    chk("clr_win_cycle4", cycle_count_4, 0);
    chk("clr_win_phase", phase_4, 1);
    pulse_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
